// File: rtl/piso_pkg.sv
// Shared types and defaults for the parallel-in/serial-out transmitter.
// Holds the FSM state encoding and the default word width.
package piso_pkg;

  localparam int DEFAULT_DATA_WIDTH = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } txState_e;

endpackage : piso_pkg

// File: rtl/piso_tx_if.sv
// Load handshake plus serial output bundle for piso_tx.
// The master modport is the word producer; the slave modport is the transmitter.
interface piso_tx_if
  import piso_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

  logic [DATA_WIDTH-1:0] loadData;
  logic                  loadValid;
  logic                  loadReady;
  logic                  dataOut;
  logic                  bitValid;
  logic                  lastBit;

  modport master (
    output loadData,
    output loadValid,
    input  loadReady,
    input  dataOut,
    input  bitValid,
    input  lastBit
  );

  modport slave (
    input  loadData,
    input  loadValid,
    output loadReady,
    output dataOut,
    output bitValid,
    output lastBit
  );

endinterface : piso_tx_if

// File: rtl/piso_tx_bit_counter.sv
// Bit-position counter for the transmitter: clears to 0, counts up on enable,
// and saturates at DATA_WIDTH-1, which it flags as terminal.
module bit_counter
  import piso_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic fastClk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(DATA_WIDTH - 1);

  logic [CW-1:0] countReg;

  assign terminal = (countReg == LAST_COUNT);

  always_ff @(posedge fastClk) begin
    if (reset || clear) begin
      countReg <= '0;
    end else if (enable && !terminal) begin
      countReg <= countReg + 1'b1;
    end
  end

endmodule : bit_counter

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter: accepts a word on a valid/ready load
// and emits it MSB first, one bit per fastClk cycle, with back-to-back support.
module piso_tx
  import piso_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic     fastClk,
  input  logic     reset,
  piso_tx_if.slave bus
);

  generate
    if (DATA_WIDTH < 2) begin : gWidthCheck
      $error("piso_tx: DATA_WIDTH must be at least 2");
    end
  endgenerate

  txState_e              stateReg;
  logic [DATA_WIDTH-1:0] shiftReg;
  logic                  terminal;
  logic                  inShift;
  logic                  lastBitInt;
  logic                  loadReadyInt;
  logic                  accept;

  assign inShift      = (stateReg == SHIFT);
  assign lastBitInt   = inShift && terminal;
  // Ready during the final bit lets the next word follow with no idle gap.
  assign loadReadyInt = !inShift || lastBitInt;
  assign accept       = bus.loadValid && loadReadyInt;

  assign bus.loadReady = loadReadyInt;
  assign bus.lastBit   = lastBitInt;
  assign bus.bitValid  = inShift;
  assign bus.dataOut   = inShift && shiftReg[DATA_WIDTH-1];

  // Clearing on the final bit leaves the counter at 0 whenever the block idles.
  bit_counter #(
    .DATA_WIDTH(DATA_WIDTH)
  ) uBitCounter (
    .fastClk (fastClk),
    .reset   (reset),
    .clear   (accept || lastBitInt),
    .enable  (inShift),
    .terminal(terminal)
  );

  always_ff @(posedge fastClk) begin
    if (reset) begin
      stateReg <= IDLE;
      shiftReg <= '0;
    end else if (accept) begin
      stateReg <= SHIFT;
      shiftReg <= bus.loadData;
    end else if (inShift) begin
      shiftReg <= {shiftReg[DATA_WIDTH-2:0], 1'b0};
      if (lastBitInt) begin
        stateReg <= IDLE;
      end
    end
  end

endmodule : piso_tx

// File: tb/tb_piso_tx.sv
// Randomised and directed bench for piso_tx against a queue-based bit-stream model
// plus a loopback receiver that rebuilds each word from the serial output.
module tb_piso_tx;

  localparam int W = 4;

  logic fastClk = 1'b0;
  logic reset   = 1'b1;

  piso_tx_if #(.DATA_WIDTH(W)) bus ();

  piso_tx #(.DATA_WIDTH(W)) dut (
    .fastClk(fastClk),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 fastClk = ~fastClk;

  int checkCount = 0;
  int passCount  = 0;

  // Model: the bits still to be shown, front element is the one on the wire now.
  bit         bitQ[$];
  bit [W-1:0] curWord;
  bit [W-1:0] rxWord;
  bit [31:0]  capBits;
  int         capCount;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) begin
      passCount++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clearCapture();
    capBits  = '0;
    capCount = 0;
  endtask

  // One clock cycle: apply inputs, update the model at the edge, compare after it.
  task automatic step(input bit rst, input bit valid, input bit [W-1:0] data);
    bit modelReady;
    bit expValid, expData, expLast, expReady;
    reset         = rst;
    bus.loadValid = valid;
    bus.loadData  = data;
    modelReady    = (bitQ.size() <= 1);
    @(posedge fastClk);
    if (rst) begin
      bitQ.delete();
    end else if (valid && modelReady) begin
      bitQ.delete();
      for (int i = W - 1; i >= 0; i--) bitQ.push_back(data[i]);
      curWord = data;
    end else if (bitQ.size() > 0) begin
      void'(bitQ.pop_front());
    end
    #1;
    expValid = (bitQ.size() > 0);
    expData  = expValid ? bitQ[0] : 1'b0;
    expLast  = (bitQ.size() == 1);
    expReady = (bitQ.size() <= 1);
    check("bitValid",  {31'b0, bus.bitValid},  {31'b0, expValid});
    check("dataOut",   {31'b0, bus.dataOut},   {31'b0, expData});
    check("lastBit",   {31'b0, bus.lastBit},   {31'b0, expLast});
    check("loadReady", {31'b0, bus.loadReady}, {31'b0, expReady});
    if (bus.bitValid) begin
      rxWord   = {rxWord[W-2:0], bus.dataOut};
      capBits  = {capBits[30:0], bus.dataOut};
      capCount++;
    end
    if (expLast) check("loopback", {28'b0, rxWord}, {28'b0, curWord});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
  endtask

  initial begin
    bus.loadValid = 1'b0;
    bus.loadData  = '0;
    rxWord        = '0;
    curWord       = '0;
    clearCapture();

    // Reset then idle
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    idle(2);
    check("idle_ready", {31'b0, bus.loadReady}, 32'd1);

    // Single word 1011
    clearCapture();
    step(1'b0, 1'b1, 4'b1011);
    idle(5);
    check("single_bits",  capBits, 32'b1011);
    check("single_count", capCount, 32'd4);

    // Back-to-back 1011 then 0110 with loadValid held
    clearCapture();
    step(1'b0, 1'b1, 4'b1011);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'b0110);
    check("b2b_ready_on_last", {31'b0, bus.loadReady}, 32'd1);
    step(1'b0, 1'b1, 4'b0110);
    idle(5);
    check("b2b_bits",  capBits, 32'b10110110);
    check("b2b_count", capCount, 32'd8);

    // Load ignored while busy
    clearCapture();
    step(1'b0, 1'b1, 4'b1000);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 4'b1111);
    idle(4);
    check("ignore_bits",  capBits, 32'b1000);
    check("ignore_count", capCount, 32'd4);

    // Reset mid-word, then a fresh word
    clearCapture();
    step(1'b0, 1'b1, 4'b1101);
    step(1'b0, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    check("abort_bits",  capBits, 32'b11);
    check("abort_count", capCount, 32'd2);
    clearCapture();
    step(1'b0, 1'b1, 4'b0011);
    idle(5);
    check("fresh_bits",  capBits, 32'b0011);
    check("fresh_count", capCount, 32'd4);

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 2) != 0), W'($urandom));
    end
    idle(6);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule : tb_piso_tx

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 Parameter: DATA_WIDTH, default 4, word width in bits; SHALL be >= 2 (elaboration error otherwise).
REQ-002 fastClk  input  1  clock; all state SHALL change on its rising edge only.
REQ-003 reset  input  1  reset; synchronous, active-high; clock fastClk.
REQ-004 loadData  input  DATA_WIDTH  parallel word to transmit; sampled only on an accepted load.
REQ-005 loadValid  input  1  producer asserts when loadData is valid.
REQ-006 loadReady  output  1  block can accept a word this cycle.
REQ-007 dataOut  output  1  serial bit stream, MSB first.
REQ-008 bitValid  output  1  high while dataOut carries a word bit.
REQ-009 lastBit  output  1  high during the final (LSB) bit of a word.

Function
REQ-010 SHALL count a load as accepted at a rising edge where loadValid && loadReady are both high.
REQ-011 State machine SHALL have states IDLE and SHIFT.
- IDLE -> SHIFT on accept.
- SHIFT -> SHIFT on accept during lastBit.
- SHIFT -> IDLE at end of lastBit with no accept.
REQ-012 On accept, loadData SHALL load into an internal DATA_WIDTH shift register and the bit counter SHALL clear to 0.
REQ-013 dataOut SHALL equal shift register MSB in SHIFT; SHALL be 0 in IDLE.
REQ-014 Latency: the MSB SHALL appear on dataOut the cycle after the accept edge; one bit per cycle after that; LSB in cycle DATA_WIDTH.
REQ-015 Each SHIFT cycle without accept, register SHALL shift left by one (LSB fill 0) and counter SHALL increment.
REQ-016 Counter width SHALL be $clog2(DATA_WIDTH); it SHALL never exceed DATA_WIDTH-1 (no wrap).
REQ-017 bitValid SHALL be 1 exactly in SHIFT; 0 in IDLE.
REQ-018 lastBit SHALL be 1 when in SHIFT and counter == DATA_WIDTH-1; else 0.
REQ-019 loadReady SHALL be (state == IDLE) || lastBit (combinational). This allows back-to-back words with no idle gap.
REQ-020 loadValid while loadReady is low SHALL be ignored; loadData SHALL not be sampled; state is unaffected.
REQ-021 Back-to-back: an accept during lastBit SHALL make the new word's MSB appear in the next cycle, with bitValid held continuously high.
REQ-022 Bit order SHALL be MSB first. A receiver that shifts in at the LSB for DATA_WIDTH cycles then holds the original word.

Reset
REQ-023 While reset is high at a clock edge, the block SHALL go to IDLE, clear the shift register and counter, and ignore loadValid.
REQ-024 Outputs after reset: dataOut=0, bitValid=0, lastBit=0, loadReady=1.
REQ-025 Reset mid-word SHALL abort the word; no further bits of it are emitted; the next cycle is IDLE.

Structure
REQ-026 Shared package piso_pkg SHALL hold the state enum typedef (IDLE, SHIFT) and the default width constant.
REQ-027 The bit counter SHALL be a sub-module bit_counter (clear, enable, terminal-count output), parameterised by DATA_WIDTH.
REQ-028 All sequential logic SHALL use a single always_ff on fastClk; outputs SHALL be derived from registered state only.

Verification (DATA_WIDTH=4)
REQ-029 Reset, then idle -> dataOut=0, bitValid=0, lastBit=0, loadReady=1.
REQ-030 Single word 4'b1011, one-cycle loadValid ->
- dataOut 1,0,1,1 on cycles +1..+4.
- bitValid high exactly 4 cycles.
- lastBit high on cycle +4 only.
- loadReady low cycles +1..+3.
REQ-031 Back-to-back 4'b1011 then 4'b0110 (loadValid held) ->
- 8 contiguous bits 1,0,1,1,0,1,1,0.
- bitValid never drops.
- 2nd accept occurs on the 1st word's lastBit.
REQ-032 loadValid pulsed with 4'b1111 on cycle +2 of word 4'b1000 -> ignored; output stays 1,0,0,0, then IDLE.
REQ-033 Reset asserted on cycle +2 of word 4'b1101 -> from the next cycle bitValid=0 and dataOut=0; a fresh 4'b0011 then sends 0,0,1,1.
REQ-034 Loopback into a 4-bit LSB-shift-in receiver model for random words -> receiver word equals transmitted word after each lastBit.
